// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: requester roles, defaults,
// FSM encodings and the round-robin pointer helper.
package uart_tx_arbiter_pkg;

  localparam int TX_ARB_NUM_REQ   = 4;
  localparam int TX_ARB_TIMEOUT   = 1 << 20;
  localparam int TX_ARB_CNT_WIDTH = 21;

  // Requester slots as wired by the mode controllers.
  localparam int UART_REQ_INPUT   = 0;
  localparam int UART_REQ_DISPLAY = 1;
  localparam int UART_REQ_COMPUTE = 2;

  // Wide enough to index up to 8 requesters.
  localparam int IDX_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int num_req);
    return (int'(idx) == num_req - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first eligible index at or after the pointer,
// wrapping, returned both one-hot and as an index.
module rr_priority_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = TX_ARB_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic w_found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loops can leave a value held (which would infer a latch).
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && i_eligible[i] && ((int'(i_ptr) + k) % NUM_REQ == i)) begin
          o_grant[i] = 1'b1;
          o_idx      = IDX_W'(i);
          w_found    = 1'b1;
        end
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level arbiter sharing one UART transmitter among NUM_REQ controllers,
// with round-robin ownership and a watchdog that revokes silent owners.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = TX_ARB_NUM_REQ,
  parameter int TIMEOUT_CYCLES = TX_ARB_TIMEOUT,
  parameter int CNT_WIDTH      = TX_ARB_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_tx_data,
  input  logic [NUM_REQ-1:0]     req_tx_start,
  output logic [NUM_REQ-1:0]     req_tx_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   timeout_err,
  output logic [2:0]             timeout_id
);

  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_lockout;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_rr;
  logic [IDX_W-1:0]     r_timeout_id;
  logic [7:0]           r_tx_data;
  logic                 r_tx_start;
  logic                 r_pend;
  logic                 r_pend_age;
  logic                 r_timeout_err;
  logic [CNT_WIDTH-1:0] r_wd_cnt;

  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_pick_grant;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_own_req;
  logic                 w_own_start;
  logic [7:0]           w_own_data;
  logic                 w_busy_view;
  logic                 w_accept;
  logic                 w_wd_expired;
  logic                 w_drained;

  assign w_eligible = req & ~r_lockout;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr),
    .o_grant    (w_pick_grant),
    .o_idx      (w_pick_idx),
    .o_valid    (w_pick_valid)
  );

  // Owner's request lines, selected by the one-hot grant register.
  always_comb begin
    w_own_req   = 1'b0;
    w_own_start = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_own_req   = req[i];
        w_own_start = req_tx_start[i];
        w_own_data  = req_tx_data[8*i +: 8];
      end
    end
  end

  // pend covers the gap between our strobe and the UART raising tx_busy.
  assign w_busy_view  = tx_busy | r_tx_start | r_pend;
  assign w_accept     = (r_state == ST_GRANTED) && w_own_start && !w_busy_view;
  assign w_wd_expired = (r_state == ST_GRANTED) && !w_busy_view && !w_accept
                        && (r_wd_cnt == WD_LAST);
  assign w_drained    = !tx_busy && !r_pend && !r_tx_start;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tx_busy[i] = r_grant[i] ? w_busy_view : 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_lockout     <= '0;
      r_owner       <= '0;
      r_rr          <= '0;
      r_timeout_id  <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_age    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_lockout     <= r_lockout & req;

      if (w_accept) begin
        r_tx_data  <= w_own_data;
        r_tx_start <= 1'b1;
        r_pend     <= 1'b1;
        r_pend_age <= 1'b0;
      end else if (r_pend) begin
        if (tx_busy || r_pend_age) r_pend <= 1'b0;
        r_pend_age <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant  <= w_pick_grant;
            r_owner  <= w_pick_idx;
            r_wd_cnt <= '0;
            r_state  <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (w_accept) r_wd_cnt <= '0;
          else if (!w_busy_view) r_wd_cnt <= r_wd_cnt + 1'b1;

          // A start accepted in the same cycle req drops is still forwarded.
          if (!w_own_req) begin
            r_state <= ST_DRAIN;
          end else if (w_wd_expired) begin
            r_state       <= ST_DRAIN;
            r_timeout_err <= 1'b1;
            r_timeout_id  <= r_owner;
            r_lockout     <= (r_lockout & req) | r_grant;
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_grant <= '0;
            r_rr    <= rr_next(r_owner, NUM_REQ);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign timeout_err = r_timeout_err;
  assign timeout_id  = r_timeout_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table for basic
// ownership plus hand sequences for drain, timeout, lockout and reset.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  localparam logic [3:0] M_INPUT   = 4'(1 << UART_REQ_INPUT);
  localparam logic [3:0] M_DISPLAY = 4'(1 << UART_REQ_DISPLAY);
  localparam logic [3:0] M_COMPUTE = 4'(1 << UART_REQ_COMPUTE);

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_tx_data;
  logic [3:0]  req_tx_start;
  logic [3:0]  req_tx_busy;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        timeout_err;
  logic [2:0]  timeout_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (21)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_tx_data  (req_tx_data),
    .req_tx_start (req_tx_start),
    .req_tx_busy  (req_tx_busy),
    .grant        (grant),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .timeout_err  (timeout_err),
    .timeout_id   (timeout_id)
  );

  // UART model: busy for 10 cycles after each start, logs every byte sent.
  int         busy_cnt;
  logic [7:0] sent_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (tx_start) begin
      busy_cnt <= 10;
      sent_q.push_back(tx_data);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign tx_busy = (busy_cnt != 0);

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  start;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic        exp_tx_start;
    logic [7:0]  exp_tx_data;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] msg[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input logic [3:0] exp, input int max_cyc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant !== exp && n < max_cyc);
    check(name, grant, exp);
  endtask

  task automatic wait_timeout(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timeout_err !== 1'b1 && n < 200);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (req_tx_busy[0] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t1_ready", n < 40, 1);
    req_tx_data  = {24'hA5C3E1, b};
    req_tx_start = M_INPUT;
    @(negedge clk);
    req_tx_start = '0;
    check("t1_pulse", {tx_start, tx_data}, {1'b1, b});
    @(negedge clk);
    check("t1_single", tx_start, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "bench time limit");
  end

  initial begin
    int         n;
    logic [3:0] seen;

    //          req      start    data          grant    txs   txd    busy
    vecs[0] = '{4'b0011, 4'b0000, 32'h0000_0000, 4'b0001, 1'b0, 8'h00, 4'b1110};
    vecs[1] = '{4'b0011, 4'b0100, 32'h00AA_0000, 4'b0001, 1'b0, 8'h00, 4'b1110};
    vecs[2] = '{4'b0011, 4'b0001, 32'h0000_B141, 4'b0001, 1'b1, 8'h41, 4'b1111};
    vecs[3] = '{4'b0011, 4'b0001, 32'h0000_0042, 4'b0001, 1'b0, 8'h41, 4'b1111};
    vecs[4] = '{4'b0010, 4'b0000, 32'h0000_0000, 4'b0001, 1'b0, 8'h41, 4'b1111};
    msg = '{8'h54, 8'h31, 8'h32, 8'h20};

    rst          = 1'b1;
    req          = '0;
    req_tx_start = '0;
    req_tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset", {grant, tx_start, tx_data, timeout_err, timeout_id, req_tx_busy},
          {4'b0000, 1'b0, 8'h00, 1'b0, 3'd0, 4'b1111});
    rst = 1'b0;
    @(negedge clk);

    // Two simultaneous requests, non-owner strobe, owner strobe while busy.
    for (int i = 0; i < 5; i++) begin
      req          = vecs[i].req;
      req_tx_start = vecs[i].start;
      req_tx_data  = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i), {grant, tx_start, tx_data, req_tx_busy},
            {vecs[i].exp_grant, vecs[i].exp_tx_start, vecs[i].exp_tx_data, vecs[i].exp_busy});
    end

    // Drain waits out the UART, then exactly one idle cycle before owner 1.
    wait_grant(4'b0000, 30, "t2_release");
    @(negedge clk);
    check("t2_idle_gap", grant, M_DISPLAY);

    // rr now 2: with 0 and 2 requesting, 2 must win.
    req = M_INPUT | M_COMPUTE;
    wait_grant(4'b0000, 10, "t2_drain1");
    @(negedge clk);
    check("t2_rr_ptr", grant, M_COMPUTE);

    // Reset while owner 2's byte is on tx_start.
    req_tx_data  = {8'h11, 8'h77, 8'h33, 8'h44};
    req_tx_start = M_COMPUTE;
    @(negedge clk);
    req_tx_start = '0;
    check("t6_pre", {grant, tx_start, tx_data}, {M_COMPUTE, 1'b1, 8'h77});
    #1 rst = 1'b1;
    #1 check("t6_reset", {grant, tx_start, tx_data, req_tx_busy, timeout_err},
             {4'b0000, 1'b0, 8'h00, 4'b1111, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    req = M_DISPLAY | M_COMPUTE;
    @(negedge clk);
    check("t6_resume", grant, M_DISPLAY);
    req = '0;
    wait_grant(4'b0000, 10, "t6_release");

    // Multi-byte message "T12 " from requester 0.
    sent_q.delete();
    req = M_INPUT;
    wait_grant(M_INPUT, 10, "t1_grant");
    for (int i = 0; i < 4; i++) send_byte(msg[i]);
    req = '0;
    wait_grant(4'b0000, 40, "t1_release");
    check("t1_count", sent_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent_q.size()) check($sformatf("t1_byte%0d", i), sent_q[i], msg[i]);
    end

    // Start in the same cycle req falls: byte goes out, drain waits for busy.
    req = M_INPUT;
    wait_grant(M_INPUT, 10, "t5_grant");
    req          = '0;
    req_tx_start = M_INPUT;
    req_tx_data  = {24'h0F0F0F, 8'h5A};
    @(negedge clk);
    req_tx_start = '0;
    check("t5_sent", {grant, tx_start, tx_data}, {M_INPUT, 1'b1, 8'h5A});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant !== 4'b0000 && n < 40);
    // tx_start cycle, 10 busy cycles, then the drain exit edge.
    check("t5_drain_len", n, 12);

    // Watchdog on owner 0, then lockout until req drops.
    req = M_INPUT;
    wait_grant(M_INPUT, 10, "t4_grant");
    wait_timeout(n);
    check("t4_latency", n, TO);
    check("t4_id", timeout_id, 3'd0);
    @(negedge clk);
    check("t4_pulse_end", {timeout_err, grant}, {1'b0, 4'b0000});
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen |= grant;
    end
    check("t4_lockout", seen, 4'b0000);
    req = '0;
    @(negedge clk);
    req = M_INPUT;
    wait_grant(M_INPUT, 5, "t4_regrant");

    // Hand over to requester 2 and let it time out too.
    req = M_COMPUTE;
    wait_grant(4'b0000, 10, "t4_release");
    wait_grant(M_COMPUTE, 5, "t4b_grant");
    wait_timeout(n);
    check("t4b_latency", n, TO);
    check("t4b_id", timeout_id, 3'd2);
    req = '0;
    wait_grant(4'b0000, 10, "t4b_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
